// File: rtl/reg_file_pkg.sv
// Shared types and constants for the register-file BIST controller.
// Holds geometry, the two complementary test patterns and the FSM state encoding.
package reg_file_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ERR_W    = 8;

    localparam logic [DATA_W-1:0] PAT_A = 32'hAAAA_AAAA;
    localparam logic [DATA_W-1:0] PAT_5 = 32'h5555_5555;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    // Address is folded into the pattern so aliased registers read back differently.
    function automatic logic [DATA_W-1:0] pat(input logic p, input logic [ADDR_W-1:0] a);
        return (p ? PAT_5 : PAT_A) ^ DATA_W'(a);
    endfunction

    // r0 is hardwired to zero, so it must read back 0 whatever was written.
    function automatic logic [DATA_W-1:0] exp_val(input logic p, input logic [ADDR_W-1:0] a);
        return (a == '0) ? '0 : pat(p, a);
    endfunction

endpackage

// File: rtl/reg_file_bist_if.sv
// Register-file access bus: one write port and two combinational read ports.
interface reg_file_bist_if;
    import reg_file_pkg::*;

    logic [ADDR_W-1:0] rf_read_reg1;
    logic [ADDR_W-1:0] rf_read_reg2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_enable;

    modport master (
        output rf_read_reg1,
        output rf_read_reg2,
        output rf_write_reg,
        output rf_write_data,
        output rf_write_enable,
        input  rf_read_data1,
        input  rf_read_data2
    );

    modport slave (
        input  rf_read_reg1,
        input  rf_read_reg2,
        input  rf_write_reg,
        input  rf_write_data,
        input  rf_write_enable,
        output rf_read_data1,
        output rf_read_data2
    );

endinterface

// File: rtl/bist_checker.sv
// Dual-port read-back comparator for the register-file BIST.
// Accumulates a saturating mismatch count and latches the first failing address.
module bist_checker
    import reg_file_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              check_en,
    input  logic              pass_sel,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [ERR_W-1:0]  err_count,
    output logic [ERR_W-1:0]  err_count_nxt_c,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_addr
);

    localparam int unsigned SUM_W = ERR_W + 1;

    logic [ADDR_W-1:0] addr1_c;
    logic [ADDR_W-1:0] addr2_c;
    logic              miss1_c;
    logic              miss2_c;
    logic [SUM_W-1:0]  sum_c;

    // Port 2 walks the register file from the top down.
    assign addr1_c = idx;
    assign addr2_c = ADDR_W'(NUM_REGS - 1) - idx;

    assign miss1_c = check_en && (rd_data1 != exp_val(pass_sel, addr1_c));
    assign miss2_c = check_en && (rd_data2 != exp_val(pass_sel, addr2_c));

    assign sum_c           = SUM_W'(err_count) + SUM_W'(miss1_c) + SUM_W'(miss2_c);
    assign err_count_nxt_c = sum_c[ERR_W] ? '1 : sum_c[ERR_W-1:0];

    // Result registers; port 1 wins a same-cycle first failure.
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_addr  <= '0;
        end else if (clear) begin
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_addr  <= '0;
        end else begin
            err_count <= err_count_nxt_c;
            if (!first_fail_valid && (miss1_c || miss2_c)) begin
                first_fail_valid <= 1'b1;
                first_fail_addr  <= miss1_c ? addr1_c : addr2_c;
            end
        end
    end

endmodule

// File: rtl/reg_file_bist.sv
// Built-in self-test controller for the 32x32 register file.
// Writes two complementary patterns, reads back on both ports and reports the result.
module reg_file_bist
    import reg_file_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    reg_file_bist_if.master        rf,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_count,
    output logic                   first_fail_valid,
    output logic [ADDR_W-1:0]      first_fail_addr
);

    bist_state_e       state;
    bist_state_e       state_nxt;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] k_nxt;
    logic              p;
    logic              p_nxt;

    logic              launch_c;
    logic              last_k_c;
    logic [ERR_W-1:0]  err_count_nxt_c;

    logic              we_d;
    logic [ADDR_W-1:0] wr_reg_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [ADDR_W-1:0] rd_reg1_d;
    logic [ADDR_W-1:0] rd_reg2_d;
    logic              busy_d;
    logic              done_d;
    logic              pass_d;

    // A start while the test runs is dropped.
    assign launch_c = start && ((state == IDLE) || (state == DONE));
    assign last_k_c = (k == ADDR_W'(NUM_REGS - 1));

    // State, index and pass registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            k     <= '0;
            p     <= 1'b0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            p     <= p_nxt;
        end
    end

    // Next-state: WRITE all, READ all, once per pattern.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        p_nxt     = p;
        case (state)
            IDLE, DONE: begin
                if (launch_c) begin
                    state_nxt = WRITE;
                    k_nxt     = '0;
                    p_nxt     = 1'b0;
                end
            end
            WRITE: begin
                if (last_k_c) begin
                    state_nxt = READ;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + ADDR_W'(1);
                end
            end
            READ: begin
                if (last_k_c) begin
                    k_nxt = '0;
                    if (!p) begin
                        p_nxt     = 1'b1;
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    k_nxt = k + ADDR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is registered.
    always_comb begin
        we_d      = 1'b0;
        wr_reg_d  = '0;
        wr_data_d = '0;
        rd_reg1_d = rf.rf_read_reg1;
        rd_reg2_d = rf.rf_read_reg2;
        busy_d    = busy;
        done_d    = done;
        pass_d    = pass;
        case (state_nxt)
            WRITE: begin
                we_d      = 1'b1;
                wr_reg_d  = k_nxt;
                wr_data_d = pat(p_nxt, k_nxt);
                busy_d    = 1'b1;
                done_d    = 1'b0;
                pass_d    = 1'b0;
            end
            READ: begin
                rd_reg1_d = k_nxt;
                rd_reg2_d = ADDR_W'(NUM_REGS - 1) - k_nxt;
                busy_d    = 1'b1;
            end
            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                // The final read compare lands on the same edge as done.
                if (state == READ) begin
                    pass_d = (err_count_nxt_c == '0);
                end
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                pass_d = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rf.rf_write_enable <= 1'b0;
            rf.rf_write_reg    <= '0;
            rf.rf_write_data   <= '0;
            rf.rf_read_reg1    <= '0;
            rf.rf_read_reg2    <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
        end else begin
            rf.rf_write_enable <= we_d;
            rf.rf_write_reg    <= wr_reg_d;
            rf.rf_write_data   <= wr_data_d;
            rf.rf_read_reg1    <= rd_reg1_d;
            rf.rf_read_reg2    <= rd_reg2_d;
            busy               <= busy_d;
            done               <= done_d;
            pass               <= pass_d;
        end
    end

    bist_checker u_checker (
        .clock            (clock),
        .reset            (reset),
        .clear            (launch_c),
        .check_en         (state == READ),
        .pass_sel         (p),
        .idx              (k),
        .rd_data1         (rf.rf_read_data1),
        .rd_data2         (rf.rf_read_data2),
        .err_count        (err_count),
        .err_count_nxt_c  (err_count_nxt_c),
        .first_fail_valid (first_fail_valid),
        .first_fail_addr  (first_fail_addr)
    );

endmodule

// File: tb/tb_reg_file_bist.sv
// Scoreboard bench for reg_file_bist with a behavioural register file and injectable faults.
module tb_reg_file_bist;
    import reg_file_pkg::*;

    localparam int FM_NONE  = 0;
    localparam int FM_R0    = 1;
    localparam int FM_STUCK = 2;
    localparam int FM_ALIAS = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic              first_fail_valid;
    logic [ADDR_W-1:0] first_fail_addr;

    reg_file_bist_if rf();

    reg_file_bist dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .rf               (rf),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_addr  (first_fail_addr)
    );

    always #5 clock = ~clock;

    // Behavioural register file: synchronous write, combinational read.
    int                fault_mode = FM_NONE;
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [DATA_W-1:0] raw1;
    logic [DATA_W-1:0] raw2;

    always @(posedge clock) begin
        if (rf.rf_write_enable) begin
            mem[rf.rf_write_reg] <= rf.rf_write_data;
            if (fault_mode == FM_ALIAS && rf.rf_write_reg == 5'd17) mem[1] <= rf.rf_write_data;
        end
    end

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a,
                                                     input logic [DATA_W-1:0] raw, input int fm);
        logic [DATA_W-1:0] v;
        v = raw;
        if (a == 5'd0 && fm != FM_R0) v = '0;
        if (a == 5'd5 && fm == FM_STUCK) v[3] = 1'b0;
        return v;
    endfunction

    assign raw1 = mem[rf.rf_read_reg1];
    assign raw2 = mem[rf.rf_read_reg2];
    assign rf.rf_read_data1 = model_read(rf.rf_read_reg1, raw1, fault_mode);
    assign rf.rf_read_data2 = model_read(rf.rf_read_reg2, raw2, fault_mode);

    // Scoreboard
    typedef struct {
        int e_err;
        bit e_ffv;
        int e_ffa;
        bit e_pass;
        int e_len;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] bench_pat(input int p, input int a);
        logic [DATA_W-1:0] base;
        base = (p == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
        return base ^ DATA_W'(a);
    endfunction

    // Monitor: checks every write and pops a scoreboard entry on each done rise.
    bit   busy_q  = 1'b0;
    bit   done_q  = 1'b0;
    int   run_len = 0;
    int   wcnt    = 0;

    always @(negedge clock) begin
        exp_t e;
        if (busy && !busy_q) wcnt = 0;
        if (rf.rf_write_enable) begin
            check("wr_reg", longint'(rf.rf_write_reg), longint'(wcnt % 32));
            check("wr_data", longint'(rf.rf_write_data), longint'(bench_pat((wcnt / 32) % 2, wcnt % 32)));
            wcnt++;
        end
        if (done && !done_q) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("err_count", longint'(err_count), longint'(e.e_err));
                check("pass", longint'(pass), longint'(e.e_pass));
                check("first_fail_valid", longint'(first_fail_valid), longint'(e.e_ffv));
                check("first_fail_addr", longint'(first_fail_addr), longint'(e.e_ffa));
                check("busy_cycles", longint'(run_len), longint'(e.e_len));
            end
        end
        if (busy) run_len++;
        else run_len = 0;
        busy_q = busy;
        done_q = done;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 400) begin
            tick(1);
            n++;
        end
        check("done_seen", longint'(done), 1);
        tick(2);
    endtask

    task automatic push_exp(input int err, input bit ffv, input int ffa);
        sb_q.push_back('{e_err: err, e_ffv: ffv, e_ffa: ffa, e_pass: (err == 0), e_len: 128});
    endtask

    // Full run; mid_start > 0 fires an extra start at that busy cycle.
    task automatic run(input int fm, input int err, input bit ffv, input int ffa, input int mid_start);
        fault_mode = fm;
        push_exp(err, ffv, ffa);
        pulse_start();
        if (mid_start > 0) begin
            tick(mid_start - 1);
            pulse_start();
        end
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
        tick(2);
        check("rst_write_enable", longint'(rf.rf_write_enable), 0);
        check("rst_write_reg", longint'(rf.rf_write_reg), 0);
        check("rst_write_data", longint'(rf.rf_write_data), 0);
        check("rst_read_reg1", longint'(rf.rf_read_reg1), 0);
        check("rst_read_reg2", longint'(rf.rf_read_reg2), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_pass", longint'(pass), 0);
        check("rst_err_count", longint'(err_count), 0);
        check("rst_ffv", longint'(first_fail_valid), 0);
        check("rst_ffa", longint'(first_fail_addr), 0);
        reset = 1'b1;
        tick(2);

        run(FM_NONE, 0, 1'b0, 0, 0);
        run(FM_NONE, 0, 1'b0, 0, 50);
        run(FM_R0, 4, 1'b1, 0, 0);

        // Restart from DONE with prior failures: results clear on the accepting edge.
        fault_mode = FM_NONE;
        push_exp(0, 1'b0, 0);
        pulse_start();
        check("restart_done", longint'(done), 0);
        check("restart_busy", longint'(busy), 1);
        check("restart_err", longint'(err_count), 0);
        check("restart_ffv", longint'(first_fail_valid), 0);
        wait_done();

        run(FM_STUCK, 2, 1'b1, 5, 0);
        run(FM_ALIAS, 4, 1'b1, 1, 0);

        // Reset mid-WRITE aborts the run immediately.
        fault_mode = FM_NONE;
        pulse_start();
        tick(9);
        reset = 1'b0;
        tick(1);
        check("abort_write_enable", longint'(rf.rf_write_enable), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_err", longint'(err_count), 0);
        reset = 1'b1;
        tick(1);
        run(FM_NONE, 0, 1'b0, 0, 0);

        check("scoreboard_empty", longint'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/reg_file_bist.md
Name: reg_file_bist

Overview:
- Built-in self-test controller that sits on the master side of the 32x32 register file (`reg_file`).
- Drives the write port and both read ports, then checks the read data.
- Exercises every register with two complementary data patterns and confirms that r0 stays hardwired to zero.
- Reports pass/fail, mismatch count and first failing address to the lab top level.

Parameters:
- NUM_REGS, 32, number of registers tested; must equal 2^ADDR_W.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to run the test; honoured only in IDLE or DONE.
- rf_read_data1  input  DATA_W  from register file read port 1 (combinational read).
- rf_read_data2  input  DATA_W  from register file read port 2 (combinational read).
- rf_read_reg1  output  ADDR_W  register file read address 1.
- rf_read_reg2  output  ADDR_W  register file read address 2.
- rf_write_reg  output  ADDR_W  register file write address.
- rf_write_data  output  DATA_W  register file write data.
- rf_write_enable  output  1  register file write strobe.
- busy  output  1  high while the test runs.
- done  output  1  high from test completion until the next start or reset.
- pass  output  1  valid while done=1; 1 iff err_count==0.
- err_count  output  8  total mismatches; saturates at 255.
- first_fail_valid  output  1  set on the first mismatch.
- first_fail_addr  output  ADDR_W  address of the first mismatch.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE and every output is registered to 0.
  - Pass counter and index counter k clear to 0.
  - Reset overrides everything, including mid-test; the write strobe drops at that same edge.
- All rf_* outputs are registered. The register file read is combinational, so the compare uses rf_read_data* in the same cycle the address is on rf_read_reg*.
- Pattern: pat(p,a) = (p==0 ? 32'hAAAA_AAAA : 32'h5555_5555) ^ zero-extended a.
- Expected value: exp(p,a) = (a==0) ? 0 : pat(p,a).
- FSM states and transitions:
  - IDLE: rf_write_enable=0. On start: busy=1, err_count=0, first_fail_valid=0, first_fail_addr=0, p=0, k=0; go to WRITE.
  - WRITE: rf_write_enable=1, rf_write_reg=k, rf_write_data=pat(p,k), with k running 0..NUM_REGS-1. r0 is written deliberately. After k=NUM_REGS-1: k=0, go to READ. The last write commits on the same edge that enters READ.
  - READ: rf_write_enable=0, rf_read_reg1=k, rf_read_reg2=NUM_REGS-1-k.
    - Compare rf_read_data1 against exp(p,k) and rf_read_data2 against exp(p,NUM_REGS-1-k).
    - Each mismatching port adds 1 to err_count, saturating.
    - First mismatch overall: first_fail_valid=1 and first_fail_addr gets that port's address. If both ports fail in that cycle, port 1 wins.
    - After k=NUM_REGS-1: if p==0, set p=1, k=0 and go to WRITE; otherwise go to DONE.
  - DONE: busy=0, done=1, pass=(err_count==0), all results held. On start: done=0 and behave as IDLE+start.
- start while busy is ignored.
- Run length: exactly 4*NUM_REGS = 128 busy cycles from the edge that samples start to the edge that sets done.
- rf_read_reg1/rf_read_reg2 hold their last value outside READ.
- rf_write_reg and rf_write_data are don't-care when rf_write_enable=0 (driven to 0).

Decomposition:
- Shared package `reg_file_pkg`:
  - ADDR_W, DATA_W, NUM_REGS.
  - Pattern constants PAT_A=32'hAAAA_AAAA and PAT_5=32'h5555_5555.
  - FSM state enum {IDLE, WRITE, READ, DONE}.
- Natural sub-module `bist_checker`:
  - Combinational expected-value generation plus dual-port compare.
  - Registered err_count, first_fail_valid and first_fail_addr.
  - The FSM stays in `reg_file_bist`.

Test Plan:
- Healthy `reg_file` connected; reset low 2 cycles; start pulse -> busy high exactly 128 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
- Behavioural model where r0 is writable -> r0 fails on port1 at k=0 and port2 at k=31 in each pass -> err_count=4, first_fail_addr=0, pass=0.
- Model with r5 bit 3 stuck-at-0 -> pass 0 expects 0xAAAAAAAF and fails on both ports; pass 1 expects 0x55555550 and passes -> err_count=2, first_fail_addr=5.
- Model where writes to r17 also write r1 (address alias) -> r1 reads pat(p,17) -> err_count=4, first_fail_addr=1.
- Assert reset low at busy cycle 10 (mid-WRITE) -> next edge: rf_write_enable=0, busy=0, done=0, err_count=0; a fresh start completes in 128 cycles with pass=1.
- Pulse start at busy cycle 50 -> ignored, done still at cycle 128. Pulse start in DONE -> done=0 next edge, results cleared, full rerun.
